cache_line_fill_ctrl: RTL and testbench
=======================================

// Module: cache_line_fill_ctrl
// PURPOSE
//   Miss-handling sequencer for the data cache (64 sets x 8 words/line). On a miss it writes back a
//   dirty victim line, burst-reads the new line from memory, and writes each beat into the data array.
//   It drives the array's one-hot set enable and word select, then commits tag/valid.
//   Sits between the cache hit/miss logic and the memory interface.
// PARAMETERS
//   ADDR_W  32  byte address width; addr = {tag, set[5:0], word[2:0], byte[2:0]}
//   DATA_W  64  word / beat width
//   TAG_W   ADDR_W-12  tag width (derived; must not be overridden)
// PORTS
//   clk             in   1       clock, rising edge
//   rst_n           in   1       asynchronous reset, active low
//   miss_valid      in   1       miss request
//   miss_ready      out  1       high only in IDLE; a miss is accepted when miss_valid & miss_ready
//   miss_addr       in   ADDR_W  missing address; captured on accept
//   miss_dirty      in   1       victim line is dirty; captured on accept
//   victim_tag      in   TAG_W   victim tag; captured on accept
//   mem_req_valid   out  1       memory burst request
//   mem_req_ready   in   1       request accepted when valid & ready
//   mem_req_we      out  1       1 = writeback burst, 0 = read burst
//   mem_req_addr    out  ADDR_W  line-aligned address; low 6 bits are 0 (CWF: word bits = first word)
//   mem_wvalid      out  1       writeback beat valid
//   mem_wready      in   1       writeback beat consumed when wvalid & wready
//   mem_wdata       out  DATA_W  writeback beat data
//   mem_rvalid      in   1       read beat valid; no backpressure
//   mem_rdata       in   DATA_W  read beat data
//   arr_set_en      out  64      one-hot set enable; all zero when idle
//   arr_word_sel    out  8       one-hot word select
//   arr_we          out  1       array write strobe
//   arr_re          out  1       array read strobe; arr_rdata valid the next cycle
//   arr_wdata       out  DATA_W  array write data (= mem_rdata, combinational)
//   arr_rdata       in   DATA_W  array read data
//   tag_we          out  1       tag RAM write for set arr_set_en
//   tag_wdata       out  TAG_W   tag to write
//   tag_valid_wdata out  1       valid bit to write (dirty bit is always written 0)
//   fill_done       out  1       one-cycle pulse on commit
//   busy            out  1       ~(state == IDLE)
// BEHAVIOUR
//   Reset: state = IDLE, all counters 0, all outputs 0 except miss_ready = 1.
//   States: IDLE -> (dirty ? WB_REQ : RD_REQ); WB_REQ -> WB_DATA on req handshake;
//     WB_DATA -> RD_REQ after beat 7 handshake; RD_REQ -> RD_DATA on req handshake;
//     RD_DATA -> COMMIT after 8th rvalid; COMMIT -> IDLE (one cycle).
//   WB_DATA, per beat k = 0..7: one cycle with arr_re = 1 and word_sel = onehot(k).
//     The next cycle drives mem_wvalid = 1 with mem_wdata = arr_rdata (registered copy).
//     This is held until mem_wready. Array reads are never issued ahead of an unconsumed beat.
//   WB address = {victim_tag, set, 6'b0}. RD address = {miss tag, set, 6'b0}.
//   RD_REQ, first cycle: tag_we = 1, tag_valid_wdata = 0 (invalidate the line before fill).
//   RD_DATA: each mem_rvalid gives arr_we = 1 for the current word, then the word counter increments.
//     mem_rvalid in any other state is ignored.
//   COMMIT: tag_we = 1, tag_wdata = miss tag, tag_valid_wdata = 1, fill_done = 1.
//   arr_set_en = onehot(set) whenever busy. Word counter is 3 bits and wraps 7 -> 0.
//   Latency (clean miss, ready memory, back-to-back rvalid): accept at T, req at T+1,
//     beats T+2..T+9, fill_done at T+10, miss_ready at T+11.
//   mem_req_valid, once asserted, is held with stable addr/we until ready (no retraction).
//   Reset mid-operation aborts immediately to IDLE. No commit: the line stays invalid if the
//     invalidate already occurred; a partial writeback is lost.
// CONFIGURATION
//   CACHE_CWF_EN defined: critical-word-first.
//     Read burst starts at miss word w. Beats go w, w+1, ..., 7, 0, ..., w-1 (mod 8).
//     mem_req_addr word bits = w. Writeback order is unchanged (0..7).
//   CACHE_CWF_EN undefined: read always starts at word 0; miss word is ignored.
// TESTING
//   Clean miss, addr 0x0000_1A28 (set 0x28, word 5): read req addr 0x1A00.
//     8 beats land in words 0..7 of set 40 only. Invalidate on first RD_REQ cycle; fill_done at T+10.
//   Dirty miss, victim_tag 0x3, set 63: WB req addr {0x3, 6'd63, 6'b0}.
//     arr_re then wvalid for each word 0..7; read burst starts only after beat 7; arr_set_en[63] = 1.
//   Backpressure: hold mem_req_ready = 0 for 5 cycles and toggle mem_wready.
//     Req addr/we stay stable; no beat is lost or duplicated; wdata matches array contents.
//   Gaps in mem_rvalid (1 of every 3 cycles): exactly 8 arr_we pulses, in word order.
//     A stray rvalid in IDLE causes no array write.
//   rst_n low during RD_DATA beat 4: all outputs 0 next edge-independent; miss_ready = 1.
//     No fill_done; a new miss then completes normally.
//   CACHE_CWF_EN, miss word 5: arr_word_sel sequence 5,6,7,0,1,2,3,4; req word bits = 5.

Source files
------------

// File: rtl/cache_line_fill_ctrl_if.sv
// rtl/cache_line_fill_ctrl_if.sv - miss, memory, data-array and tag-RAM signals of the line-fill controller
interface cache_line_fill_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    localparam int TAG_W = ADDR_W - 12;

    logic              miss_valid;
    logic              miss_ready;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_dirty;
    logic [TAG_W-1:0]  victim_tag;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [63:0]       arr_set_en;
    logic [7:0]        arr_word_sel;
    logic              arr_we;
    logic              arr_re;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;
    logic              tag_we;
    logic [TAG_W-1:0]  tag_wdata;
    logic              tag_valid_wdata;
    logic              fill_done;
    logic              busy;

    modport master (
        input  miss_valid, miss_addr, miss_dirty, victim_tag,
        input  mem_req_ready, mem_wready, mem_rvalid, mem_rdata, arr_rdata,
        output miss_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_wvalid, mem_wdata,
        output arr_set_en, arr_word_sel, arr_we, arr_re, arr_wdata,
        output tag_we, tag_wdata, tag_valid_wdata, fill_done, busy
    );

    modport slave (
        output miss_valid, miss_addr, miss_dirty, victim_tag,
        output mem_req_ready, mem_wready, mem_rvalid, mem_rdata, arr_rdata,
        input  miss_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_wvalid, mem_wdata,
        input  arr_set_en, arr_word_sel, arr_we, arr_re, arr_wdata,
        input  tag_we, tag_wdata, tag_valid_wdata, fill_done, busy
    );
endinterface

// File: rtl/cache_line_fill_ctrl.sv
// rtl/cache_line_fill_ctrl.sv - data-cache miss sequencer: victim writeback, line fill, tag commit
// CACHE_CWF_EN selects critical-word-first read bursts.
module cache_line_fill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cache_line_fill_ctrl_if.master bus
);
    localparam int TAG_W = ADDR_W - 12;

    typedef enum logic [2:0] {
        S_IDLE, S_WB_REQ, S_WB_DATA, S_RD_REQ, S_RD_DATA, S_COMMIT
    } state_t;

    state_t            state_q, state_d;
    logic [TAG_W-1:0]  tag_q, vtag_q;
    logic [5:0]        set_q;
    logic [2:0]        word_q, cnt_q;
    logic              wv_q, fresh_q, inv_done_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        in_start, rd_start;
    logic              unused_addr_bits;
    logic              accept, req_hs;

`ifdef CACHE_CWF_EN
    logic [2:0] mword_q;
    assign in_start         = bus.miss_addr[5:3];
    assign rd_start         = mword_q;
    assign unused_addr_bits = ^bus.miss_addr[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mword_q <= 3'd0;
        else if (accept) mword_q <= bus.miss_addr[5:3];
    end
`else
    assign in_start         = 3'd0;
    assign rd_start         = 3'd0;
    assign unused_addr_bits = ^bus.miss_addr[5:0];
`endif

    assign accept = (state_q == S_IDLE) && bus.miss_valid;
    assign req_hs = bus.mem_req_valid && bus.mem_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = bus.miss_dirty ? S_WB_REQ : S_RD_REQ;
            S_WB_REQ:  if (req_hs) state_d = S_WB_DATA;
            S_WB_DATA: if (wv_q && bus.mem_wready && word_q == 3'd7) state_d = S_RD_REQ;
            S_RD_REQ:  if (req_hs) state_d = S_RD_DATA;
            S_RD_DATA: if (bus.mem_rvalid && cnt_q == 3'd7) state_d = S_COMMIT;
            S_COMMIT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Writeback beat: one arr_re cycle, then wvalid held; first wvalid cycle forwards arr_rdata live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q      <= '0;
            vtag_q     <= '0;
            set_q      <= 6'd0;
            word_q     <= 3'd0;
            cnt_q      <= 3'd0;
            wv_q       <= 1'b0;
            fresh_q    <= 1'b0;
            inv_done_q <= 1'b0;
            wdata_q    <= '0;
        end else begin
            inv_done_q <= (state_q == S_RD_REQ);
            case (state_q)
                S_IDLE: if (accept) begin
                    tag_q  <= bus.miss_addr[ADDR_W-1:12];
                    set_q  <= bus.miss_addr[11:6];
                    vtag_q <= bus.victim_tag;
                    word_q <= bus.miss_dirty ? 3'd0 : in_start;
                    cnt_q  <= 3'd0;
                end
                S_WB_DATA: if (!wv_q) begin
                    wv_q    <= 1'b1;
                    fresh_q <= 1'b1;
                end else begin
                    fresh_q <= 1'b0;
                    if (fresh_q) wdata_q <= bus.arr_rdata;
                    if (bus.mem_wready) begin
                        wv_q   <= 1'b0;
                        word_q <= (word_q == 3'd7) ? rd_start : word_q + 3'd1;
                    end
                end
                S_RD_DATA: if (bus.mem_rvalid) begin
                    word_q <= word_q + 3'd1;
                    cnt_q  <= cnt_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.miss_ready      = (state_q == S_IDLE);
        bus.busy            = (state_q != S_IDLE);
        bus.mem_req_valid   = (state_q == S_WB_REQ) || (state_q == S_RD_REQ);
        bus.mem_req_we      = (state_q == S_WB_REQ);
        bus.mem_req_addr    = '0;
        if (state_q == S_WB_REQ) bus.mem_req_addr = {vtag_q, set_q, 6'b0};
        if (state_q == S_RD_REQ) bus.mem_req_addr = {tag_q, set_q, rd_start, 3'b0};
        bus.mem_wvalid      = (state_q == S_WB_DATA) && wv_q;
        bus.mem_wdata       = bus.mem_wvalid ? (fresh_q ? bus.arr_rdata : wdata_q) : '0;
        bus.arr_set_en      = bus.busy ? (64'd1 << set_q) : 64'd0;
        bus.arr_word_sel    = bus.busy ? (8'd1 << word_q) : 8'd0;
        bus.arr_re          = (state_q == S_WB_DATA) && !wv_q;
        bus.arr_we          = (state_q == S_RD_DATA) && bus.mem_rvalid;
        bus.arr_wdata       = bus.mem_rdata;
        bus.tag_we          = ((state_q == S_RD_REQ) && !inv_done_q) || (state_q == S_COMMIT);
        bus.tag_wdata       = bus.tag_we ? tag_q : '0;
        bus.tag_valid_wdata = (state_q == S_COMMIT);
        bus.fill_done       = (state_q == S_COMMIT);
    end
endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// tb/tb_cache_line_fill_ctrl.sv - scoreboard bench for cache_line_fill_ctrl
module tb_cache_line_fill_ctrl;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_line_fill_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    cache_line_fill_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic [5:0]  set;
        logic [2:0]  word;
        logic [63:0] data;
    } wr_t;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;
    int we_cnt = 0;
    int fill_cnt = 0;
    logic [63:0] arr_m [64][8];
    wr_t         exp_wr[$];
    logic [63:0] exp_wb[$];
    logic [32:0] exp_req[$];

    function automatic int oh_idx(input logic [63:0] v);
        int r = 0;
        for (int i = 0; i < 64; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Data array: registered read, data valid the cycle after arr_re.
    always @(posedge clk)
        if (bus.arr_re) bus.arr_rdata <= arr_m[oh_idx(bus.arr_set_en)][oh_idx({56'd0, bus.arr_word_sel})];

    always @(negedge clk) begin
        wr_t e;
        logic [63:0] d;
        logic [32:0] r;
        if (rst_n && bus.arr_we) begin
            we_cnt++;
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL arr_we_unexpected: set_en=%h word_sel=%h, required no write", bus.arr_set_en, bus.arr_word_sel);
            end else begin
                e = exp_wr.pop_front();
                if (bus.arr_set_en !== (64'd1 << e.set) || bus.arr_word_sel !== (8'd1 << e.word) || bus.arr_wdata !== e.data) begin
                    bad++;
                    $display("FAIL arr_write: got set_en=%h sel=%h data=%h, required set=%0d word=%0d data=%h",
                             bus.arr_set_en, bus.arr_word_sel, bus.arr_wdata, e.set, e.word, e.data);
                end
                arr_m[e.set][e.word] = e.data;
            end
        end
        if (rst_n && bus.mem_wvalid && bus.mem_wready) begin
            total++;
            if (exp_wb.size() == 0) begin
                bad++;
                $display("FAIL wb_beat_unexpected: data=%h", bus.mem_wdata);
            end else begin
                d = exp_wb.pop_front();
                if (bus.mem_wdata !== d) begin
                    bad++;
                    $display("FAIL wb_data: got %h, required %h", bus.mem_wdata, d);
                end
            end
        end
        if (rst_n && bus.mem_req_valid && bus.mem_req_ready) begin
            total++;
            if (exp_req.size() == 0) begin
                bad++;
                $display("FAIL req_unexpected: we=%b addr=%h", bus.mem_req_we, bus.mem_req_addr);
            end else begin
                r = exp_req.pop_front();
                if ({bus.mem_req_we, bus.mem_req_addr} !== r) begin
                    bad++;
                    $display("FAIL req: got we=%b addr=%h, required we=%b addr=%h", bus.mem_req_we, bus.mem_req_addr, r[32], r[31:0]);
                end
            end
            if (!bus.mem_req_we) begin
                total++;
                if (exp_wb.size() != 0) begin
                    bad++;
                    $display("FAIL rd_before_wb_done: pending beats %0d, required 0", exp_wb.size());
                end
            end
        end
        if (rst_n && bus.fill_done) fill_cnt++;
    end

    task automatic check_idle_outputs(input string tag);
        total++;
        if (bus.miss_ready !== 1'b1 || bus.busy !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.mem_wvalid !== 1'b0 ||
            bus.arr_set_en !== 64'd0 || bus.arr_we !== 1'b0 || bus.arr_re !== 1'b0 || bus.tag_we !== 1'b0 ||
            bus.fill_done !== 1'b0 || bus.mem_req_addr !== 32'd0) begin
            bad++;
            $display("FAIL %s: ready=%b busy=%b req=%b wv=%b set_en=%h we=%b re=%b tag_we=%b done=%b, required idle",
                     tag, bus.miss_ready, bus.busy, bus.mem_req_valid, bus.mem_wvalid, bus.arr_set_en,
                     bus.arr_we, bus.arr_re, bus.tag_we, bus.fill_done);
        end
    endtask

    task automatic run_miss(input logic [31:0] addr, input logic dirty, input logic [19:0] vtag,
                            input int req_stall, input bit toggle_w, input int rgap, input int abort_beat, input bit chk_lat);
        logic [5:0]  set = addr[11:6];
        logic [19:0] tag = addr[31:12];
        logic [2:0]  start;
        logic [63:0] beats [8];
        logic [31:0] hold_addr;
        logic        hold_we, hold_v, inv_chk, rd_ok, go, acc, done, aborted;
        int acc_edge, fill_edge, sent, stall, we0, fill0;
`ifdef CACHE_CWF_EN
        start = addr[5:3];
`else
        start = 3'd0;
`endif
        for (int b = 0; b < 8; b++) begin
            beats[b] = {$urandom, $urandom};
            exp_wr.push_back({set, start + 3'(b), beats[b]});
        end
        if (dirty) begin
            exp_req.push_back({1'b1, vtag, set, 6'b0});
            for (int k = 0; k < 8; k++) exp_wb.push_back(arr_m[set][k]);
        end
        exp_req.push_back({1'b0, tag, set, start, 3'b0});
        we0 = we_cnt; fill0 = fill_cnt;
        acc = 0; done = 0; aborted = 0; acc_edge = 0; fill_edge = 0;
        @(posedge clk); #1;
        bus.miss_valid = 1'b1; bus.miss_addr = addr; bus.miss_dirty = dirty; bus.victim_tag = vtag;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            if (bus.miss_ready) begin
                @(posedge clk); #1;
                acc = 1; acc_edge = edge_cnt;
                bus.miss_valid = 1'b0;
            end
        end
        if (!acc) begin
            bad++; total++;
            $display("FAIL accept_timeout: miss_ready never seen, required 1");
            return;
        end
        sent = 0; stall = 0; hold_v = 0; inv_chk = 0; rd_ok = 0; hold_addr = 0; hold_we = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (abort_beat >= 0 && sent == abort_beat) begin
                rst_n = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_req_ready = 1'b0;
                #1;
                check_idle_outputs("reset_mid_fill");
                exp_wr.delete(); exp_wb.delete(); exp_req.delete();
                aborted = 1; done = 1;
            end else begin
                go = 0;
                if (bus.mem_req_valid) begin
                    if (!hold_v) begin
                        hold_v = 1; hold_addr = bus.mem_req_addr; hold_we = bus.mem_req_we; stall = 0;
                    end else begin
                        total++;
                        if (bus.mem_req_addr !== hold_addr || bus.mem_req_we !== hold_we) begin
                            bad++;
                            $display("FAIL req_stable: got we=%b addr=%h, required we=%b addr=%h", bus.mem_req_we, bus.mem_req_addr, hold_we, hold_addr);
                        end
                    end
                    if (!bus.mem_req_we && !inv_chk) begin
                        inv_chk = 1; total++;
                        if (bus.tag_we !== 1'b1 || bus.tag_valid_wdata !== 1'b0) begin
                            bad++;
                            $display("FAIL invalidate: tag_we=%b valid=%b, required 1/0", bus.tag_we, bus.tag_valid_wdata);
                        end
                    end
                    bus.mem_req_ready = (stall >= req_stall);
                    stall++;
                    if (bus.mem_req_ready) begin
                        hold_v = 0;
                        go = !bus.mem_req_we;
                    end
                end else bus.mem_req_ready = 1'b0;
                bus.mem_wready = toggle_w ? ((c % 2) == 0) : 1'b1;
                if (rd_ok && sent < 8 && (c % rgap) == 0) begin
                    bus.mem_rvalid = 1'b1; bus.mem_rdata = beats[sent]; sent++;
                end else begin
                    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
                end
                rd_ok = rd_ok | go;
                if (bus.fill_done) begin
                    fill_edge = edge_cnt; done = 1; total++;
                    if (bus.tag_we !== 1'b1 || bus.tag_wdata !== tag || bus.tag_valid_wdata !== 1'b1 || bus.arr_set_en !== (64'd1 << set)) begin
                        bad++;
                        $display("FAIL commit: tag_we=%b tag=%h valid=%b set_en=%h, required 1/%h/1/set %0d",
                                 bus.tag_we, bus.tag_wdata, bus.tag_valid_wdata, bus.arr_set_en, tag, set);
                    end
                end
            end
            @(posedge clk); #1;
        end
        bus.mem_rvalid = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_wready = 1'b0;
        if (!done) begin
            bad++; total++;
            $display("FAIL fill_timeout: fill_done not seen, required within 400 cycles");
        end
        if (aborted) begin
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            total++;
            if (fill_cnt != fill0 || we_cnt - we0 != abort_beat) begin
                bad++;
                $display("FAIL abort_counts: fills=%0d writes=%0d, required 0/%0d", fill_cnt - fill0, we_cnt - we0, abort_beat);
            end
            return;
        end
        check_idle_outputs("after_commit");
        total++;
        if (fill_cnt - fill0 != 1 || we_cnt - we0 != 8 || exp_wr.size() != 0 || exp_wb.size() != 0 || exp_req.size() != 0) begin
            bad++;
            $display("FAIL completion: fills=%0d writes=%0d left wr=%0d wb=%0d req=%0d, required 1/8/0/0/0",
                     fill_cnt - fill0, we_cnt - we0, exp_wr.size(), exp_wb.size(), exp_req.size());
        end
        if (chk_lat) begin
            total++;
            if (fill_edge - acc_edge != 9) begin
                bad++;
                $display("FAIL latency: fill_done %0d edges after accept, required 9", fill_edge - acc_edge);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        check_idle_outputs("reset_state");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle_outputs("after_release");
    endtask

    task automatic test_clean_miss();
        run_miss(32'h0000_1A28, 1'b0, 20'h0, 0, 1'b0, 1, -1, 1'b1);
    endtask

    task automatic test_dirty_miss();
        run_miss({20'h00055, 6'd63, 3'd2, 3'd0}, 1'b1, 20'h3, 0, 1'b0, 1, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_miss({20'h0ABCD, 6'd17, 3'd6, 3'd0}, 1'b1, 20'h7_1234, 5, 1'b1, 1, -1, 1'b0);
    endtask

    task automatic test_rvalid_gaps();
        run_miss({20'h00ACE, 6'd9, 3'd3, 3'd0}, 1'b0, 20'h0, 0, 1'b0, 3, -1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
            @(negedge clk);
            total++;
            if (bus.arr_we !== 1'b0) begin
                bad++;
                $display("FAIL stray_rvalid: arr_we=%b, required 0", bus.arr_we);
            end
        end
        @(posedge clk); #1 bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        run_miss({20'h12345, 6'd5, 3'd1, 3'd0}, 1'b0, 20'h0, 0, 1'b0, 1, 4, 1'b0);
        run_miss({20'h12345, 6'd5, 3'd1, 3'd0}, 1'b0, 20'h0, 0, 1'b0, 1, -1, 1'b1);
    endtask

    task automatic test_cwf();
        run_miss({20'h00777, 6'd33, 3'd5, 3'd0}, 1'b0, 20'h0, 2, 1'b0, 1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_miss({20'h00BEE, 6'd40, 3'd7, 3'd0}, 1'b1, 20'h0_0001, 0, 1'b1, 2, -1, 1'b0);
        run_miss({20'h00F00, 6'd40, 3'd0, 3'd0}, 1'b1, 20'h00BEE, 1, 1'b0, 1, -1, 1'b0);
    endtask

    initial begin
        bus.miss_valid = 1'b0; bus.miss_addr = '0; bus.miss_dirty = 1'b0; bus.victim_tag = '0;
        bus.mem_req_ready = 1'b0; bus.mem_wready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        bus.arr_rdata = '0;
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 8; w++) arr_m[s][w] = {$urandom, $urandom};
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_backpressure();
        test_rvalid_gaps();
        test_reset_mid_fill();
        test_cwf();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
